// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution engine: sequencer state
// encoding, output-dimension arithmetic and the default address widths.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MULT,
    WAIT,
    NEXT,
    DONE
  } conv_state_t;

  localparam int RESULT_W = 16;

  function automatic int out_dim(input int img, input int filt);
    return img - filt + 1;
  endfunction

  // Never returns zero, so degenerate 1-wide dimensions still get a real bus.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IMAGE_WIDTH  = 9;
  localparam int DEF_IMAGE_HEIGHT = 9;
  localparam int DEF_FILTER_SIZE  = 3;
  localparam int DEF_OUT_W        = out_dim(DEF_IMAGE_WIDTH, DEF_FILTER_SIZE);
  localparam int DEF_OUT_H        = out_dim(DEF_IMAGE_HEIGHT, DEF_FILTER_SIZE);
  localparam int DEF_ADDR_W       = width_of(DEF_OUT_W * DEF_OUT_H);

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter for the output map: column runs fastest, and 'last'
// flags the bottom-right position.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int ROWS  = DEF_OUT_H,
  parameter int COLS  = DEF_OUT_W,
  parameter int ROW_W = width_of(ROWS),
  parameter int COL_W = width_of(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic row_end;
  logic col_end;

  assign col_end = (col == COL_W'(COLS - 1));
  assign row_end = (row == ROW_W'(ROWS - 1));
  assign last    = row_end && col_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM that walks every output position, requests its window, fires the
// multiply and writes the result. Optional WAIT timeout: CONV_SEQ_TIMEOUT_EN.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH    = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT   = DEF_IMAGE_HEIGHT,
  parameter int FILTER_SIZE    = DEF_FILTER_SIZE,
`ifdef CONV_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 16,
`endif
  parameter int OUT_W          = out_dim(IMAGE_WIDTH, FILTER_SIZE),
  parameter int OUT_H          = out_dim(IMAGE_HEIGHT, FILTER_SIZE),
  parameter int ADDR_W         = width_of(OUT_W * OUT_H),
  parameter int ROW_W          = width_of(OUT_H),
  parameter int COL_W          = width_of(OUT_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                win_req,
  output logic [ROW_W-1:0]    win_row,
  output logic [COL_W-1:0]    win_col,
  input  logic                win_ready,
  output logic                mult_en,
  input  logic                conv_valid,
  input  logic [RESULT_W-1:0] conv_result,
  output logic                out_wr_en,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [RESULT_W-1:0] out_data
);

  conv_state_t      state;
  conv_state_t      next_state;
  logic             clear_pos;
  logic             advance_pos;
  logic             last;
  logic             timed_out;
  logic             accept;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  assign clear_pos   = (state == IDLE) && start;
  assign advance_pos = (state == NEXT);
  assign accept      = (state == WAIT) && conv_valid;

  conv_pos_counter #(
    .ROWS (OUT_H),
    .COLS (OUT_W),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_pos),
    .advance(advance_pos),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (win_ready) next_state = MULT;
      MULT:    next_state = WAIT;
      WAIT: begin
        if (conv_valid)     next_state = NEXT;
        else if (timed_out) next_state = DONE;
      end
      NEXT:    next_state = last ? DONE : FETCH;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control strobes decode from the state register alone, so no input reaches
  // an output combinationally.
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign win_req = (state == FETCH);
  assign mult_en = (state == MULT);
  assign win_row = row;
  assign win_col = col;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_wr_en <= accept;
      if (accept) begin
        out_addr <= ADDR_W'(row) * ADDR_W'(OUT_W) + ADDR_W'(col);
        out_data <= conv_result;
      end
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int WAIT_CNT_W = width_of(TIMEOUT_CYCLES + 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  err_q;

  // Counter idles at zero outside WAIT, which gives the clear-on-entry behaviour.
  assign timed_out = (state == WAIT) && !conv_valid &&
                     (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != WAIT)   wait_cnt <= '0;
      else if (!conv_valid) wait_cnt <= wait_cnt + 1'b1;
      if (clear_pos)      err_q <= 1'b0;
      else if (timed_out) err_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomised bench for conv_sequencer: a 2-cycle datapath model drives results
// and a transaction-level scoreboard checks window order, write order and timing.
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int OW   = DEF_OUT_W;
  localparam int OH   = DEF_OUT_H;
  localparam int NPOS = OW * OH;
  localparam int AW   = DEF_ADDR_W;
  localparam int RW   = width_of(OH);
  localparam int CW   = width_of(OW);
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err, win_req, mult_en, out_wr_en;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_ready   = 1'b0;
  logic          conv_valid  = 1'b0;
  logic [15:0]   conv_result = '0;
  logic [AW-1:0] out_addr;
  logic [15:0]   out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int delay_mode = 0;
  bit spur_en    = 1'b0;
  int silent_pos = -1;

  int          cur_delay = 0;
  int          fetch_len = 0;
  bit          pending   = 1'b0;
  int          due_cyc   = 0;
  logic [15:0] due_data  = '0;

  int          exp_idx = 0, mult_idx = 0, mult_cyc = 0, last_wr_cyc = 0;
  int          wreq_cnt = 0, silent_cyc = 0, done_cnt = 0;
  bit          wr_pending = 1'b0, silent_hit = 1'b0, exp_err = 1'b0;
  logic [15:0] wr_data [NPOS];

  conv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .win_req    (win_req),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_ready  (win_ready),
    .mult_en    (mult_en),
    .conv_valid (conv_valid),
    .conv_result(conv_result),
    .out_wr_en  (out_wr_en),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Environment: window unit with per-position latency and a datapath that
  // answers two cycles after mult_en with row*10+col of the requested window.
  always begin
    @(posedge clk);
    #1;
    if (mult_en === 1'b1) begin
      pending  = (mult_idx != silent_pos);
      due_cyc  = cyc + 2;
      due_data = 16'(int'(win_row) * 10 + int'(win_col));
    end
    if (win_req === 1'b1) begin
      fetch_len++;
      if (fetch_len == 1) begin
        if (delay_mode == 1)      cur_delay = (mult_idx == 18) ? 3 : 0;
        else if (delay_mode == 2) cur_delay = int'($urandom_range(0, 3));
        else                      cur_delay = 0;
      end
      win_ready = (fetch_len > cur_delay);
    end else begin
      fetch_len = 0;
      win_ready = spur_en && ($urandom_range(0, 1) == 1);
    end
    if (pending && due_cyc == cyc) begin
      conv_valid  = 1'b1;
      conv_result = due_data;
      pending     = 1'b0;
    end else begin
      conv_valid  = spur_en && (win_req || !busy) && ($urandom_range(0, 1) == 1);
      conv_result = 16'($urandom);
    end
  end

  // Scoreboard: positions come out in raster order, each write lands three
  // cycles after its multiply, and done follows the last write or the timeout.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check_output("err_flag", err, exp_err);
      if (win_req || mult_en || done) check_output("busy_when_active", busy, 1);
      if (win_req) wreq_cnt++;
      if (mult_en) begin
        check_output("mult_row", win_row, mult_idx / OW);
        check_output("mult_col", win_col, mult_idx % OW);
        check_output("fetch_cycles", wreq_cnt, cur_delay + 1);
        check_output("mult_before_write", wr_pending, 0);
        wreq_cnt = 0;
        mult_cyc = cyc;
        if (mult_idx == silent_pos) begin
          silent_hit = 1'b1;
          silent_cyc = cyc;
        end else begin
          wr_pending = 1'b1;
        end
        mult_idx++;
      end
      if (out_wr_en) begin
        check_output("write_expected", wr_pending, 1);
        check_output("write_cycle", cyc, mult_cyc + 3);
        check_output("write_addr", out_addr, exp_idx);
        check_output("write_data", out_data, (exp_idx / OW) * 10 + exp_idx % OW);
        if (exp_idx < NPOS) wr_data[exp_idx] = out_data;
        wr_pending  = 1'b0;
        last_wr_cyc = cyc;
        exp_idx++;
      end
      if (done) begin
        if (silent_hit) begin
          check_output("timeout_done_cycle", cyc, silent_cyc + TMO + 1);
          check_output("timeout_writes", exp_idx, silent_pos);
        end else begin
          check_output("done_writes", exp_idx, NPOS);
          check_output("done_mults", mult_idx, NPOS);
          check_output("done_cycle", cyc, last_wr_cyc + 1);
        end
        done_cnt++;
      end
      if (rst) begin
        exp_err    = 1'b0;
        wr_pending = 1'b0;
      end else if (start && !busy) begin
        exp_err    = 1'b0;
        exp_idx    = 0;
        mult_idx   = 0;
        wreq_cnt   = 0;
        wr_pending = 1'b0;
        silent_hit = 1'b0;
      end else if (silent_hit && cyc == silent_cyc + TMO) begin
        exp_err = 1'b1;
      end
    end
  end

  task automatic apply_stimulus(output int rel, input int busy_start_at);
    int sc;
    bit seen;
    @(posedge clk);
    #1;
    start = 1'b1;
    sc    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("err_after_start", err, 0);
    seen = 1'b0;
    rel  = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy_start_at > 0) start = (cyc == sc + busy_start_at);
      if (done) begin
        seen = 1'b1;
        rel  = cyc - sc;
        break;
      end
    end
    start = 1'b0;
    if (!seen) check_output("done_timeout", 0, 1);
    @(negedge clk);
    check_output("busy_after_done", busy, 0);
    check_output("done_single_cycle", done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_err"}, err, 0);
    check_output({tag, "_win_req"}, win_req, 0);
    check_output({tag, "_mult_en"}, mult_en, 0);
    check_output({tag, "_out_wr_en"}, out_wr_en, 0);
    check_output({tag, "_win_row"}, win_row, 0);
    check_output({tag, "_win_col"}, win_col, 0);
    check_output({tag, "_out_addr"}, out_addr, 0);
    check_output({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    int rel;
    int dc;
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    dc = done_cnt;
    apply_stimulus(rel, 0);
    check_output("run1_done_cycle", rel, 246);
    check_output("run1_data_addr48", wr_data[48], 66);
    check_output("run1_writes", exp_idx, 49);
    check_output("run1_mults", mult_idx, 49);
    check_output("run1_done_pulses", done_cnt - dc, 1);

    delay_mode = 1;
    spur_en    = 1'b1;
    dc = done_cnt;
    apply_stimulus(rel, 10);
    check_output("run2_done_cycle", rel, 249);
    check_output("run2_data_addr18", wr_data[18], 24);
    check_output("run2_done_pulses", done_cnt - dc, 1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_output("idle_spurious_writes", exp_idx, 49);

    delay_mode = 2;
    dc = done_cnt;
    apply_stimulus(rel, 0);
    check_output("run3_writes", exp_idx, 49);
    check_output("run3_done_pulses", done_cnt - dc, 1);

    delay_mode = 0;
    spur_en    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (mult_en && mult_idx == 20) begin
        found = 1'b1;
        break;
      end
    end
    check_output("reach_pos20", found, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    repeat (4) @(posedge clk);
    dc = done_cnt;
    apply_stimulus(rel, 0);
    check_output("after_reset_done_cycle", rel, 246);
    check_output("after_reset_addr0", wr_data[0], 0);
    check_output("after_reset_writes", exp_idx, 49);
    check_output("after_reset_done_pulses", done_cnt - dc, 1);

`ifdef CONV_SEQ_TIMEOUT_EN
    silent_pos = 5;
    apply_stimulus(rel, 0);
    check_output("timeout_rel_cycle", rel, 44);
    check_output("timeout_err_sticky", err, 1);
    silent_pos = -1;
    apply_stimulus(rel, 0);
    check_output("post_timeout_done_cycle", rel, 246);
    check_output("post_timeout_err", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control FSM that drives the convolution datapath over a full image. It raster-scans every valid output position, requests the matching FILTER_SIZE×FILTER_SIZE window from the window/shift unit, and pulses the datapath's multiply enable. It waits for the datapath's result-valid, then writes each 16-bit result to the output feature-map memory. It sits between the top-level start/done interface, the window buffer, the convolve datapath and the output RAM.

## Interface
Parameters:
- IMAGE_WIDTH, 9: input image columns
- IMAGE_HEIGHT, 9: input image rows
- FILTER_SIZE, 3: kernel edge length
- OUT_W / OUT_H, derived: IMAGE_WIDTH−FILTER_SIZE+1 / IMAGE_HEIGHT−FILTER_SIZE+1
- ADDR_W, derived: clog2(OUT_W*OUT_H)
- TIMEOUT_CYCLES, 16: result-wait limit, used only when the timeout feature is compiled in

Ports:
- clk, in, 1: the single clock
- rst, in, 1: synchronous, active-high reset
- start, in, 1: one-cycle request to process one image
- busy, out, 1: high from the cycle after start is accepted until DONE exits
- done, out, 1: one-cycle completion pulse
- err, out, 1: sticky timeout flag
- win_req, out, 1: level request to the window unit for the position on win_row/win_col
- win_row, out, clog2(OUT_H): top-left row of the requested window
- win_col, out, clog2(OUT_W): top-left column of the requested window
- win_ready, in, 1: window for the current position is stable on the datapath input
- mult_en, out, 1: one-cycle pulse to the convolve datapath
- conv_valid, in, 1: datapath result-valid
- conv_result, in, 16: datapath result
- out_wr_en, out, 1: output RAM write strobe
- out_addr, out, ADDR_W: write address, row*OUT_W+col
- out_data, out, 16: write data

## Operation
- States: IDLE, FETCH, MULT, WAIT, NEXT, DONE.
- IDLE: start=1 sets row=0, col=0, busy=1, clears err, and moves to FETCH. start is ignored in every other state.
- FETCH: win_req=1. When win_ready=1 the FSM moves to MULT. Otherwise it holds with no limit.
- MULT: mult_en=1 for exactly this cycle, then the FSM moves to WAIT.
- WAIT: When conv_valid=1, the registers load out_wr_en=1, out_data=conv_result and out_addr=row*OUT_W+col, and the FSM moves to NEXT.
- NEXT: The raster counter advances with col incrementing first. When col=OUT_W−1, col wraps to 0 and row increments. At the last position (row=OUT_H−1, col=OUT_W−1) the FSM goes to DONE; otherwise it goes to FETCH.
- DONE: done=1 and busy drops to 0 on the following edge. The FSM returns to IDLE.
- conv_valid outside WAIT is ignored and produces no write.
- win_ready outside FETCH is ignored.
- out_addr arithmetic is unsigned with no overflow, because OUT_W*OUT_H ≤ 2^ADDR_W.
- Reset at any cycle forces the FSM to IDLE immediately. Any in-flight result is dropped and no write occurs.

## Timing
- Reset values: busy, done, err, win_req, mult_en and out_wr_en are 0. win_row, win_col, out_addr and out_data are 0.
- All outputs are registered or decoded from the state register only, with no input-to-output combinational paths.
- win_req is high for every FETCH cycle. mult_en is high for exactly 1 cycle per position.
- out_wr_en is high for exactly 1 cycle, the NEXT cycle, per position. out_addr and out_data are valid in that same cycle.
- With win_ready tied high and a 2-cycle datapath, each position takes 5 cycles: FETCH 1, MULT 1, WAIT 2, NEXT 1.
- Under those conditions with the defaults (49 positions), start is sampled in cycle 0 and done is high in cycle 246.

## Configuration
- Macro: CONV_SEQ_TIMEOUT_EN.
- Defined: a WAIT-cycle counter is cleared on WAIT entry. If it reaches TIMEOUT_CYCLES without conv_valid, err is set, no write occurs and the FSM goes to DONE. err stays set until the next accepted start or until reset.
- Undefined: the counter is not built, err is tied to 0, and WAIT holds until conv_valid arrives.

## Structure
- Shared package conv_pkg holds:
  - the state enum
  - the out_dim(img, filt) function
  - the address-width localparams, for reuse by the window unit and the output RAM
- One sub-module, conv_pos_counter: the row/col raster counter with clear, advance and last outputs.

## Test plan
- Defaults, win_ready=1, 2-cycle datapath model returning row*10+col → 49 writes, out_addr 0..48 in order, out_data at addr 48 is 66, done in cycle 246, mult_en pulsed exactly 49 times.
- win_ready delayed 3 cycles at position (2,4) → win_req held 4 cycles, no mult_en pulse until win_ready, single write at addr 18.
- Spurious conv_valid during FETCH and IDLE → no out_wr_en, counters unchanged.
- start asserted in cycle 10 while busy → ignored, and the run still ends with one done pulse.
- rst asserted in a WAIT cycle at position 20 → next cycle all outputs at reset values. A fresh start then rewrites from addr 0.
- CONV_SEQ_TIMEOUT_EN defined, datapath silent at position 5 → err=1 after 16 WAIT cycles, then done. A new start clears err.
